unsigned_seq_div_16x8: RTL and testbench
========================================

# unsigned_seq_div_16x8

Sequential unsigned restoring divider that inverts the 8x8 unsigned multipliers: it takes a 16-bit product-width dividend `z` and an 8-bit operand `y`, and recovers the 8-bit quotient `x` and 8-bit remainder `r` over eight iteration cycles. It sits beside the approximate multipliers in the error-characterisation datapath. It checks that `y*x + r` reconstructs `z` and measures how the truncated-partial-product multipliers lose information. Input and output are valid/ready streams, and one operation is in flight at a time.

## Interface
Parameters:
- `L`, default 2: number of low dividend bits truncated when `APPROX_DIV_EN` is defined. Legal range 0..7.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `in_valid`, input, 1: `z`/`y` valid.
- `in_ready`, output, 1: block can accept an operation.
- `z`, input, 16: dividend.
- `y`, input, 8: divisor.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `x`, output, 8: quotient.
- `r`, output, 8: remainder.
- `ovf`, output, 1: quotient does not fit in 8 bits, or `y==0`.
- `div0`, output, 1: divisor was zero.

## Operation
- States: IDLE, CALC, DONE.
- `in_ready` = (state==IDLE). `out_valid` = (state==DONE).
- Accept on a rising edge with `in_valid & in_ready`. At that edge:
  - `y==0`: load `x`=8'hFF, `r`=0, `div0`=1, `ovf`=1, go to DONE.
  - Else if `z[15:8] >= y`: load `x`=8'hFF, `r`=0, `ovf`=1, `div0`=0, go to DONE.
  - Else: partial remainder `p`=`z[15:8]`, shift register `d`=`z[7:0]`, latch `y`, `cnt`=7, `ovf`=`div0`=0, go to CALC.
- CALC step, one per edge:
  - Compute `t` = {p, d[7]} (9 bits; cannot overflow because `p`<`y`).
  - If `t >= y`: `p` = `t - y` and the quotient bit is 1. Otherwise `p` = `t[7:0]` and the quotient bit is 0.
  - Shift `d` left, shifting the quotient bit into its LSB. `d` doubles as the quotient register.
  - `cnt` decrements; after the step with `cnt==0`, go to DONE.
- DONE: `x`=`d`, `r`=`p`. Outputs are held stable until `out_valid & out_ready`, then go to IDLE.
- Inputs presented while not in IDLE are ignored (`in_ready`=0). No queueing.
- Invariant for non-overflow results: `y*x + r == z'` and `r < y`. Here `z'` is the effective dividend (see Configuration).

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `x`=0, `r`=0, `ovf`=0, `div0`=0, `cnt`=0.
- Normal latency:
  - Accept edge E; CALC steps on edges E+1..E+8.
  - `out_valid` is high in the cycle after E+8.
- Exception latency (`div0`/`ovf`): `out_valid` is high in the cycle after E.
- Result handshake:
  - On an edge with `out_valid & out_ready`, the block returns to IDLE and `in_ready`=1 the next cycle.
  - Minimum issue interval is 10 cycles for a normal operation and 2 for an exception.
- `in_ready` and `out_valid` are never high together. There is no combinational path from `out_ready` to `in_ready`.
- `rst` asserted in any state, including mid-CALC or DONE under backpressure:
  - Outputs immediately take their reset values.
  - The in-flight operation is discarded; no partial result is emitted.
- Outputs `x`, `r`, `ovf`, `div0` are registered. Their values outside DONE are don't-care, but they must not glitch while `out_valid`=1.

## Configuration
- `APPROX_DIV_EN` undefined: exact division, with effective dividend `z'`=`z`.
- `APPROX_DIV_EN` defined:
  - `z'` = `z` with bits [`L`-1:0] forced to 0 at accept.
  - This mirrors the low-column truncation of the l=`L` multipliers.
  - The overflow check and all steps use `z'`. Latency and handshake are unchanged.

## Structure
- Package `unsigned_div_pkg`:
  - State enum `div_state_t` (IDLE, CALC, DONE).
  - Width constants `DIV_ZW`=16 and `DIV_XW`=8.
  - Exception-result constants `DIV_SAT_Q`=8'hFF and `DIV_SAT_R`=8'h00.
- Sub-module `div_restore_step`:
  - Purely combinational single restoring iteration.
  - Inputs: `p[7:0]`, `bit_in`, `y[7:0]`. Outputs: `p_next[7:0]`, `q_bit`.
  - The top level holds the FSM, counter and registers.

## Test plan
- `z`=16'h3039 (12345), `y`=100, `out_ready`=1 → `out_valid` in the cycle after E+8 with `x`=123, `r`=45, `ovf`=0, `div0`=0.
- `z`=16'hFE01, `y`=255 → `x`=255, `r`=0, `ovf`=0. Then `z`=16'hFF00, `y`=255 → `x`=8'hFF, `r`=0, `ovf`=1, `out_valid` in the cycle after E.
- `z`=1234, `y`=0 → `div0`=1, `ovf`=1, `x`=8'hFF, `r`=0, latency 1.
- Hold `out_ready`=0 for 5 cycles after DONE while toggling `in_valid` with new operands → outputs stable, `in_ready`=0, no new accept. Raise `out_ready` → IDLE next cycle.
- Assert `rst` during CALC with `cnt`=4 → `out_valid`=0 and `in_ready`=1 after release. Next operation `z`=500, `y`=7 → `x`=71, `r`=3.
- With `APPROX_DIV_EN` and `L`=2: `z`=16'h3039, `y`=100 → `z'`=12344, so `x`=123, `r`=44.

Source files
------------

// File: rtl/unsigned_div_pkg.sv
// Shared types and constants for the sequential 16/8 unsigned divider.
package unsigned_div_pkg;

    // Control states of the divider FSM.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Dividend (product) width and quotient/divisor width.
    localparam int unsigned DIV_ZW = 16;
    localparam int unsigned DIV_XW = 8;

    // Result reported for divide-by-zero and quotient overflow.
    localparam logic [DIV_XW-1:0] DIV_SAT_Q = 8'hFF;
    localparam logic [DIV_XW-1:0] DIV_SAT_R = 8'h00;

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// subtract the divisor when it fits, and report the resulting quotient bit.
module div_restore_step
    import unsigned_div_pkg::*;
(
    input  logic [DIV_XW-1:0] p,
    input  logic              bit_in,
    input  logic [DIV_XW-1:0] y,
    output logic [DIV_XW-1:0] p_next,
    output logic              q_bit
);

    logic [DIV_XW:0] t;
    logic [DIV_XW:0] diff;

    // Trial subtraction; t fits in 9 bits because p < y always holds.
    always_comb begin
        t      = {p, bit_in};
        diff   = t - {1'b0, y};
        q_bit  = (t >= {1'b0, y});
        p_next = q_bit ? diff[DIV_XW-1:0] : t[DIV_XW-1:0];
    end

endmodule

// File: rtl/unsigned_seq_div_16x8.sv
// Sequential unsigned restoring divider, 16-bit dividend by 8-bit divisor,
// producing an 8-bit quotient and remainder over eight iteration cycles.
// Define APPROX_DIV_EN to zero the L low dividend bits at accept, matching the
// low-column truncation of the approximate multipliers.
module unsigned_seq_div_16x8
    import unsigned_div_pkg::*;
#(
    parameter int unsigned L = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIV_ZW-1:0] z,
    input  logic [DIV_XW-1:0] y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DIV_XW-1:0] x,
    output logic [DIV_XW-1:0] r,
    output logic              ovf,
    output logic              div0
);

    localparam logic [DIV_ZW-1:0] LOW_MASK = DIV_ZW'((32'd1 << L) - 32'd1);
`ifdef APPROX_DIV_EN
    localparam bit APPROX_ON = 1'b1;
`else
    localparam bit APPROX_ON = 1'b0;
`endif

    div_state_t        state_q, state_d;
    logic [DIV_XW-1:0] p_q, p_d;      // partial remainder
    logic [DIV_XW-1:0] d_q, d_d;      // dividend low bits, becomes quotient
    logic [DIV_XW-1:0] y_q, y_d;      // latched divisor
    logic [2:0]        cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              div0_q, div0_d;

    logic [DIV_ZW-1:0] z_eff;
    logic [DIV_XW-1:0] step_p;
    logic              step_q;

    // Effective dividend: optionally truncate the low L bits.
    always_comb begin
        z_eff = APPROX_ON ? (z & ~LOW_MASK) : z;
    end

    div_restore_step u_step (
        .p      (p_q),
        .bit_in (d_q[DIV_XW-1]),
        .y      (y_q),
        .p_next (step_p),
        .q_bit  (step_q)
    );

    // Next-state and datapath update for accept, iterate and result hold.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        d_d     = d_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        div0_d  = div0_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (y == '0) begin
                        d_d     = DIV_SAT_Q;
                        p_d     = DIV_SAT_R;
                        ovf_d   = 1'b1;
                        div0_d  = 1'b1;
                        state_d = DONE;
                    end else if (z_eff[DIV_ZW-1:DIV_XW] >= y) begin
                        d_d     = DIV_SAT_Q;
                        p_d     = DIV_SAT_R;
                        ovf_d   = 1'b1;
                        div0_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        p_d     = z_eff[DIV_ZW-1:DIV_XW];
                        d_d     = z_eff[DIV_XW-1:0];
                        y_d     = y;
                        cnt_d   = 3'd7;
                        ovf_d   = 1'b0;
                        div0_d  = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                p_d   = step_p;
                d_d   = {d_q[DIV_XW-2:0], step_q};
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            d_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            d_q     <= d_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            div0_q  <= div0_d;
        end
    end

    // Handshake flags come straight from the state register, and results
    // straight from the datapath registers, so nothing glitches in DONE.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        x         = d_q;
        r         = p_q;
        ovf       = ovf_q;
        div0      = div0_q;
    end

endmodule

// File: tb/tb_unsigned_seq_div_16x8.sv
// Randomised and directed bench for unsigned_seq_div_16x8 against an
// arithmetic reference model.
module tb_unsigned_seq_div_16x8;

    localparam int unsigned L = 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] z;
    logic [7:0]  y;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  x;
    logic [7:0]  r;
    logic        ovf;
    logic        div0;

    int total = 0;
    int bad   = 0;

    unsigned_seq_div_16x8 #(.L(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .r         (r),
        .ovf       (ovf),
        .div0      (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: integer division of the effective dividend.
    task automatic model(input logic [15:0] zi, input logic [7:0] yi,
                         output logic [7:0] ex, output logic [7:0] er,
                         output logic eovf, output logic ediv0, output int elat);
        int zeff;
        int q;
        zeff = int'(zi);
`ifdef APPROX_DIV_EN
        zeff = zeff - (zeff % (1 << L));
`endif
        if (yi == 8'd0) begin
            ex = 8'hFF; er = 8'h00; eovf = 1'b1; ediv0 = 1'b1; elat = 1;
        end else begin
            q = zeff / int'(yi);
            if (q > 255) begin
                ex = 8'hFF; er = 8'h00; eovf = 1'b1; ediv0 = 1'b0; elat = 1;
            end else begin
                ex = 8'(q); er = 8'(zeff % int'(yi)); eovf = 1'b0; ediv0 = 1'b0; elat = 9;
            end
        end
    endtask

    // Issue one operation, check latency and result, hold backpressure for
    // 'hold' cycles (optionally toggling in_valid), then retire it.
    task automatic run_op(input logic [15:0] zi, input logic [7:0] yi,
                          input int hold, input bit toggle);
        logic [7:0] ex, er;
        logic       eovf, ediv0;
        int         elat, lat, n;
        model(zi, yi, ex, er, eovf, ediv0, elat);
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_val("in_ready_before", 32'(in_ready), 32'd1);
        z = zi; y = yi; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; z = 16'($urandom); y = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check_val("latency", 32'(lat), 32'(elat));
        check_val("x", 32'(x), 32'(ex));
        check_val("r", 32'(r), 32'(er));
        check_val("ovf", 32'(ovf), 32'(eovf));
        check_val("div0", 32'(div0), 32'(ediv0));
        check_val("in_ready_busy", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            if (toggle) begin
                in_valid = ~in_valid; z = 16'($urandom); y = 8'($urandom);
            end
            @(negedge clk);
            check_val("hold_valid", 32'(out_valid), 32'd1);
            check_val("hold_ready", 32'(in_ready), 32'd0);
            check_val("hold_x", 32'(x), 32'(ex));
            check_val("hold_r", 32'(r), 32'(er));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_val("retire_valid", 32'(out_valid), 32'd0);
        check_val("retire_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0]  ry;
        logic [15:0] rz;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; z = '0; y = '0;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_x", 32'(x), 32'd0);
        check_val("rst_r", 32'(r), 32'd0);
        check_val("rst_ovf", 32'(ovf), 32'd0);
        check_val("rst_div0", 32'(div0), 32'd0);
        rst = 1'b0;

        run_op(16'h3039, 8'd100, 0, 1'b0);
        run_op(16'hFE01, 8'd255, 0, 1'b0);
        run_op(16'hFF00, 8'd255, 0, 1'b0);
        run_op(16'd1234, 8'd0, 0, 1'b0);
        run_op(16'd40000, 8'd200, 5, 1'b1);

        // Reset while iterating: accept, three steps, then reset mid-CALC.
        @(negedge clk);
        z = 16'd60000; y = 8'd250; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("pre_rst_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check_val("async_rst_valid", 32'(out_valid), 32'd0);
        check_val("async_rst_ready", 32'(in_ready), 32'd1);
        check_val("async_rst_x", 32'(x), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check_val("no_stale_result", 32'(out_valid), 32'd0);
        end
        run_op(16'd500, 8'd7, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ry = 8'($urandom);
            if (($urandom % 8) == 0) begin
                rz = 16'($urandom);
            end else if (ry == 8'd0) begin
                rz = 16'($urandom);
            end else begin
                rz = {8'($urandom_range(0, int'(ry) - 1)), 8'($urandom)};
            end
            run_op(rz, ry, int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
